// File: rtl/mem_access_if.sv
// rtl/mem_access_if.sv - data-memory request/acknowledge bus
interface mem_access_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_access_initiator.sv
// rtl/mem_access_initiator.sv - Y86-64 memory-stage read/write initiator with range check and timeout
module mem_access_initiator #(
    parameter logic [63:0] ADDR_LIMIT     = 64'd1023,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [3:0]         icode,
    input  logic [63:0]        vale,
    input  logic [63:0]        vala,
    input  logic [63:0]        valp,
    mem_access_if.master       mem,
    output logic [63:0]        valm,
    output logic               busy,
    output logic               done,
    output logic               memory_block_error
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   wdata_q, wdata_d;
    logic [63:0]   valm_q, valm_d;
    logic          err_q, err_d;

    logic          dec_access;
    logic          dec_we;
    logic [63:0]   dec_addr;
    logic [63:0]   dec_wdata;

    always_comb begin
        dec_access = 1'b0;
        dec_we     = 1'b0;
        dec_addr   = 64'd0;
        dec_wdata  = 64'd0;
        case (icode)
            4'd4, 4'd10: begin
                dec_access = 1'b1; dec_we = 1'b1; dec_addr = vale; dec_wdata = vala;
            end
            4'd8: begin
                dec_access = 1'b1; dec_we = 1'b1; dec_addr = vale; dec_wdata = valp;
            end
            4'd5: begin
                dec_access = 1'b1; dec_addr = vale;
            end
            4'd9, 4'd11: begin
                dec_access = 1'b1; dec_addr = vala;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        valm_d  = valm_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (!dec_access) begin
                        state_d = S_DONE;
                    end else if (dec_addr > ADDR_LIMIT) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        we_d    = dec_we;
                        addr_d  = dec_addr;
                        wdata_d = dec_wdata;
                    end
                end
            end
            S_REQ: begin
                // ack in the last allowed cycle still counts as success
                if (mem.mem_ack) begin
                    state_d = S_DONE;
                    if (!we_q) valm_d = mem.mem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= 64'd0;
            wdata_q <= 64'd0;
            valm_q  <= 64'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valm_q  <= valm_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs derive from state so an async reset drops mem_req at once.
    assign mem.mem_req   = (state_q == S_REQ);
    assign mem.mem_we    = (state_q == S_REQ) & we_q;
    assign mem.mem_addr  = (state_q == S_REQ) ? addr_q  : 64'd0;
    assign mem.mem_wdata = (state_q == S_REQ) ? wdata_q : 64'd0;

    assign valm               = valm_q;
    assign busy               = (state_q != S_IDLE);
    assign done               = (state_q == S_DONE);
    assign memory_block_error = err_q;
endmodule

// File: tb/tb_mem_access_initiator.sv
// tb/tb_mem_access_initiator.sv - self-checking bench for mem_access_initiator
module tb_mem_access_initiator;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  icode = 4'd0;
    logic [63:0] vale = 64'd0, vala = 64'd0, valp = 64'd0;
    logic [63:0] valm;
    logic        busy, done, memory_block_error;

    mem_access_if mem ();

    mem_access_initiator dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .start              (start),
        .icode              (icode),
        .vale               (vale),
        .vala               (vala),
        .valp               (valp),
        .mem                (mem),
        .valm               (valm),
        .busy               (busy),
        .done               (done),
        .memory_block_error (memory_block_error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  ic;
        logic [63:0] e, a, p;
        int          ack;
        logic [63:0] rd;
        bit          bump;
        int          req, dn;
        bit          err, we;
        logic [63:0] addr, wd, vm;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_txn(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                           input logic [63:0] p, input int ack_c, input logic [63:0] rd,
                           input bit bump, input int exp_req, input int exp_done,
                           input bit exp_err, input bit exp_we, input logic [63:0] exp_addr,
                           input logic [63:0] exp_wd, input logic [63:0] exp_valm);
        @(negedge clock);
        start = 1'b1; icode = ic; vale = e; vala = a; valp = p;
        mem.mem_ack = 1'b0;
        for (int c = 1; c <= exp_done; c++) begin
            @(posedge clock); #1;
            start = bump && (c == 1);
            if (bump && c == 1) begin
                icode = 4'd4; vale = 64'd3; vala = ~a; valp = ~p;
            end
            mem.mem_ack   = (c == ack_c);
            mem.mem_rdata = (c == ack_c) ? rd : {$urandom, $urandom};
            @(negedge clock);
            chk("mem_req", 64'(mem.mem_req), 64'(c <= exp_req));
            if (c <= exp_req) begin
                chk("mem_we", 64'(mem.mem_we), 64'(exp_we));
                chk("mem_addr", mem.mem_addr, exp_addr);
                if (exp_we) chk("mem_wdata", mem.mem_wdata, exp_wd);
                chk("err_in_req", 64'(memory_block_error), 64'd0);
            end else begin
                chk("idle_we", 64'(mem.mem_we), 64'd0);
                chk("idle_addr", mem.mem_addr, 64'd0);
            end
            chk("busy", 64'(busy), 64'd1);
            chk("done", 64'(done), 64'(c == exp_done));
            if (c == exp_done) begin
                chk("error", 64'(memory_block_error), 64'(exp_err));
                chk("valm", valm, exp_valm);
            end
        end
        @(posedge clock); #1;
        start = 1'b0; mem.mem_ack = 1'b0;
        @(negedge clock);
        chk("post_busy", 64'(busy), 64'd0);
        chk("post_done", 64'(done), 64'd0);
        chk("post_req", 64'(mem.mem_req), 64'd0);
        chk("sticky_err", 64'(memory_block_error), 64'(exp_err));
    endtask

    initial begin
        logic [63:0] model_valm;
        logic [3:0]  ic;
        logic [63:0] e, a, p, rd, addr, data;
        int          ack, req, dn;
        bit          is_w, is_r, err, bump;

        mem.mem_ack = 1'b0;
        mem.mem_rdata = 64'd0;

        //             ic     vale                    vala                    valp        ack rdata    bump req dn err we addr   wdata   valm
        tbl[0] = '{4'd4,  64'd16,  64'hAB,                64'd0,      1,  64'd0,   0, 1,  2,  0, 1, 64'd16,   64'hAB, 64'd0};
        tbl[1] = '{4'd11, 64'd0,   64'd40,                64'd0,      3,  64'h55,  1, 3,  4,  0, 0, 64'd40,   64'd0,  64'h55};
        tbl[2] = '{4'd5,  64'd1024,64'd0,                 64'd0,      1,  64'd0,   0, 0,  1,  1, 0, 64'd0,    64'd0,  64'h55};
        tbl[3] = '{4'd1,  64'd0,   64'd0,                 64'd0,      0,  64'd0,   0, 0,  1,  0, 0, 64'd0,    64'd0,  64'h55};
        tbl[4] = '{4'd8,  64'd8,   64'd0,                 64'h1234,   0,  64'd0,   1, 16, 17, 1, 1, 64'd8,    64'h1234, 64'h55};
        tbl[5] = '{4'd8,  64'd8,   64'd0,                 64'h1234,   16, 64'd0,   0, 16, 17, 0, 1, 64'd8,    64'h1234, 64'h55};
        tbl[6] = '{4'd5,  64'd1023,64'd0,                 64'd0,      2,  64'h77,  0, 2,  3,  0, 0, 64'd1023, 64'd0,  64'h77};
        tbl[7] = '{4'd9,  64'd0,   64'hFFFF_FFFF_FFFF_FFF8, 64'd0,    1,  64'd0,   0, 0,  1,  1, 0, 64'd0,    64'd0,  64'h77};
        tbl[8] = '{4'd10, 64'd5,   64'd99,                64'd7,      1,  64'd1,   0, 1,  2,  0, 1, 64'd5,    64'd99, 64'h77};
        tbl[9] = '{4'd0,  64'd3,   64'd3,                 64'd3,      0,  64'd0,   0, 0,  1,  0, 0, 64'd0,    64'd0,  64'h77};

        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_req", 64'(mem.mem_req), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_valm", valm, 64'd0);
        chk("rst_err", 64'(memory_block_error), 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].ic, tbl[i].e, tbl[i].a, tbl[i].p, tbl[i].ack, tbl[i].rd, tbl[i].bump,
                    tbl[i].req, tbl[i].dn, tbl[i].err, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].vm);
        end

        model_valm = 64'h77;
        for (int i = 0; i < 40; i++) begin
            ic   = 4'($urandom_range(0, 15));
            e    = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
            a    = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 1100));
            p    = {$urandom, $urandom};
            rd   = {$urandom, $urandom};
            ack  = $urandom_range(0, 18);
            bump = 1'($urandom_range(0, 1));
            is_w = (ic == 4 || ic == 8 || ic == 10);
            is_r = (ic == 5 || ic == 9 || ic == 11);
            addr = (ic == 9 || ic == 11) ? a : e;
            data = (ic == 8) ? p : a;
            if (!is_w && !is_r) begin
                req = 0; dn = 1; err = 0;
            end else if (addr > 64'd1023) begin
                req = 0; dn = 1; err = 1;
            end else if (ack >= 1 && ack <= 16) begin
                req = ack; dn = ack + 1; err = 0;
                if (is_r) model_valm = rd;
            end else begin
                req = 16; dn = 17; err = 1;
            end
            run_txn(ic, e, a, p, ack, rd, bump, req, dn, err, is_w, addr, data, model_valm);
        end

        // Known nonzero valm before the mid-request reset.
        run_txn(4'd5, 64'd100, 64'd0, 64'd0, 1, 64'hC0DE, 0, 1, 2, 0, 0, 64'd100, 64'd0, 64'hC0DE);
        @(negedge clock);
        start = 1'b1; icode = 4'd5; vale = 64'd200;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_req", 64'(mem.mem_req), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_req", 64'(mem.mem_req), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_valm", valm, 64'd0);
        chk("midrst_err", 64'(memory_block_error), 64'd0);
        @(posedge clock); #1;
        chk("rst_hold_done", 64'(done), 64'd0);
        reset_n = 1'b1;
        run_txn(4'd2, 64'd0, 64'd0, 64'd0, 0, 64'd0, 0, 0, 1, 0, 0, 64'd0, 64'd0, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
